// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/response channel of one requester of sram_arbiter.
//   req_valid/req_ready : request handshake (accepted on valid&ready at posedge)
//   req_wstrb           : byte write strobes, 0 = read, nonzero = write of set lanes
//   req_addr            : word address
//   req_wdata           : write data
//   rsp_valid/rsp_ready : read response handshake
//   rsp_rdata           : read data
// Modports: master = requester side, slave = arbiter side.
interface sram_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int NB = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [NB-1:0] req_wstrb;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wstrb, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wstrb, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter/sequencer for a 16K x 32 byte-writable
// single-port SRAM macro. One grant per cycle, macro pins driven from
// registers, read data returned through a one-entry buffer per port with a
// fixed 2-cycle latency from accept to rsp_valid.
//
// Ports:
//   clk, rst_n      : clock (also the macro CK), asynchronous active-low reset
//   p0, p1          : requester channels (sram_arbiter_if.slave)
//   sram_cs/oe/web  : macro chip select, output enable, per-lane write enables
//   sram_a/di       : macro address and write data
//   sram_do         : macro read data
//
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0
// wins contention, no priority pointer); default is round-robin.
module sram_arbiter #(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int NB = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave p0,
  sram_arbiter_if.slave p1,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic [NB-1:0] sram_web,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_di,
  input  logic [DW-1:0] sram_do
);

  logic [1:0]    req_rd;
  logic [1:0]    rsp_rdy;
  logic [1:0]    elig;
  logic [1:0]    gnt;
  logic [1:0]    rd_pend;
  logic          prio_port;
  logic          gnt_port;
  logic [NB-1:0] gnt_wstrb;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;

  logic          rd_vld_p0;
  logic          port_p0;
  logic          rd_vld_p1;
  logic          port_p1;
  logic [1:0]    cap_p1;
  logic [1:0]    rsp_vld_p2;
  logic [DW-1:0] rsp_rdata_p2 [2];

  assign req_rd  = {~|p1.req_wstrb, ~|p0.req_wstrb};
  assign rsp_rdy = {p1.rsp_ready, p0.rsp_ready};

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign prio_port = 1'b0;
`else
  logic ptr;

  assign prio_port = ptr;

  // Pointer always hands priority to the port that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= ~gnt_port;
    end
  end
`endif

  // A read is held off while that port still has a read in flight or an
  // unconsumed response; writes are never held off. Ready is forced low
  // while reset is asserted.
  always_comb begin
    elig[0] = p0.req_valid & ~(req_rd[0] & rd_pend[0]) & rst_n;
    elig[1] = p1.req_valid & ~(req_rd[1] & rd_pend[1]) & rst_n;
    gnt     = elig;
    if (elig == 2'b11) begin
      gnt = prio_port ? 2'b10 : 2'b01;
    end
  end

  assign gnt_port  = gnt[1];
  assign gnt_wstrb = gnt_port ? p1.req_wstrb : p0.req_wstrb;
  assign gnt_addr  = gnt_port ? p1.req_addr  : p0.req_addr;
  assign gnt_wdata = gnt_port ? p1.req_wdata : p0.req_wdata;

  assign p0.req_ready = gnt[0];
  assign p1.req_ready = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt[i] && req_rd[i]) begin
          rd_pend[i] <= 1'b1;
        end else if (rsp_vld_p2[i] && rsp_rdy[i]) begin
          rd_pend[i] <= 1'b0;
        end
      end
    end
  end

  // ---- issue stage (p0): macro pins and access tag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_oe   <= 1'b0;
      sram_cs   <= 1'b0;
      sram_web  <= '1;
      sram_a    <= '0;
      sram_di   <= '0;
      rd_vld_p0 <= 1'b0;
      port_p0   <= 1'b0;
    end else begin
      sram_oe <= 1'b1;
      if (|gnt) begin
        sram_cs   <= 1'b1;
        sram_web  <= ~gnt_wstrb;
        sram_a    <= gnt_addr;
        sram_di   <= gnt_wdata;
        rd_vld_p0 <= req_rd[gnt_port];
        port_p0   <= gnt_port;
      end else begin
        sram_cs   <= 1'b0;
        sram_web  <= '1;
        rd_vld_p0 <= 1'b0;
      end
    end
  end

  // ---- macro access stage (p1): tag follows the macro sampling edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1 <= 1'b0;
      port_p1   <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_vld_p0;
      port_p1   <= port_p0;
    end
  end

  assign cap_p1 = {rd_vld_p1 & port_p1, rd_vld_p1 & ~port_p1};

  // ---- capture stage (p2): DO into the tagged port's response buffer ----
  // rd_pend guarantees the buffer is empty whenever a capture arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p2 <= '0;
      for (int i = 0; i < 2; i++) begin
        rsp_rdata_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cap_p1[i]) begin
          rsp_vld_p2[i]   <= 1'b1;
          rsp_rdata_p2[i] <= sram_do;
        end else if (rsp_vld_p2[i] && rsp_rdy[i]) begin
          rsp_vld_p2[i] <= 1'b0;
        end
      end
    end
  end

  assign p0.rsp_valid = rsp_vld_p2[0];
  assign p1.rsp_valid = rsp_vld_p2[1];
  assign p0.rsp_rdata = rsp_rdata_p2[0];
  assign p1.rsp_rdata = rsp_rdata_p2[1];

endmodule
